ps2_key_decoder: RTL
====================

Name: ps2_key_decoder

Overview:
- Upstream stage of the hex-digit entry block.
- Receives raw PS/2 keyboard frames and tracks make/break codes, including the E0 and F0 prefixes.
- Presents level outputs for the key currently held: a one-hot hex digit vector, a backspace flag and a delete flag.
- The entry FSM consumes these levels directly: any non-zero value means a key is pressed; all zero means released.

Parameters:
- TIMEOUT_CYCLES, 50000: clk cycles with no PS/2 clock falling edge before a partial frame is discarded (1 ms at 50 MHz).
- SYNC_STAGES, 2: flip-flop synchronizer depth on ps2ck and ps2dt (minimum 2).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-low reset
- ps2ck  in  1  PS/2 clock from keyboard, asynchronous
- ps2dt  in  1  PS/2 data from keyboard, asynchronous
- numbers  out  16  one-hot held hex key; bit k = digit k (0-F); all zero = none held
- keyBackspace  out  1  high while Backspace is held
- delete  out  1  high while Delete (E0-prefixed) is held
- scan_valid  out  1  one-cycle pulse per accepted frame
- scan_code  out  8  byte of the last accepted frame, valid with scan_valid
- frame_err  out  1  one-cycle pulse per rejected frame

Behaviour:
- Reset (rst low, async): all outputs 0, receiver in IDLE, bit count 0, prefix flags ext=0 and brk=0, timeout counter 0, synchronizers filled with 1.
- Falling edge = synchronized ps2ck previous 1, current 0. ps2dt is sampled from the same synchronized stage.
- Receiver FSM:
  - IDLE -> RECV on a falling edge with data 0 (start bit). A falling edge with data 1 in IDLE is ignored.
  - RECV shifts data LSB-first on each falling edge: 8 data bits, then the parity bit, then the stop bit. It goes to CHECK on the 10th edge after the start bit.
  - Timeout counter clears on every edge. If it reaches TIMEOUT_CYCLES in RECV, go to IDLE with the partial frame dropped and no frame_err.
  - CHECK lasts one cycle, then returns to IDLE. The frame is valid when stop=1 and parity passes (see Optional Feature). Invalid: frame_err=1 for one cycle; decoder state untouched.
- Latency: scan_valid, scan_code and the key outputs all update on the clk edge after CHECK, i.e. 2 cycles after the detected 11th falling edge.
- Decoder, on each valid byte B:
  - B=E0: ext=1.
  - B=F0: brk=1.
  - Any other B is a key code; ext and brk are then cleared.
  - Make (brk=0) sets the matching output and clears all other key outputs (single-key model).
  - Break (brk=1) clears the output only if it matches the held key; otherwise ignored.
  - Unmapped codes, including E0-prefixed non-Delete codes, leave outputs unchanged.
- Key map (set 2):
  - Digits 0-9: 45,16,1E,26,25,2E,36,3D,3E,46.
  - A-F: 1C,32,21,23,24,2B.
  - Backspace: 66, no prefix.
  - Delete: E0 71 only. Plain 71 (keypad '.') is unmapped.
  - Hex digits match only without the E0 prefix.
- Typematic repeat: repeated make of the held key leaves outputs stable with no glitch.
- Invariant: at most one of numbers[15:0], keyBackspace, delete is high at any time.
- A frame_err between F0 and its code byte does not clear brk. The next valid key code completes the break.
- Reset mid-frame: everything returns to the reset values immediately; the remainder of the frame is received from IDLE and ignored until a valid start bit appears.

Optional Feature:
- Macro PS2_PARITY_CHECK_EN.
- Defined: a frame is valid only if the 8 data bits plus the parity bit contain an odd number of 1s, and stop=1. A parity failure pulses frame_err and the byte is discarded.
- Undefined: the parity bit is captured but ignored; only stop=1 is checked. Parity logic is removed.

Test Plan:
- Reset, then send frame 0x16 (odd parity) -> numbers=16'h0002 and scan_valid pulse with scan_code=8'h16, 2 clk after the 11th edge. Then send F0 16 -> numbers=0.
- Send 1C, 1C, 1C (typematic) -> numbers=16'h0400 stable through all frames. Then send F0 1C -> 0.
- Send E0 71 -> delete=1, numbers=0. Send 66 -> delete=0, keyBackspace=1. Send E0 F0 71 -> no change. Send F0 66 -> keyBackspace=0.
- Hold 45, then send F0 16 (break of a non-held key) -> numbers stays 16'h0001.
- Send frame 0x26 with a wrong parity bit -> with PS2_PARITY_CHECK_EN: frame_err pulse, numbers=0. Without the macro: numbers=16'h0008.
- Send 5 bits of a frame, stall longer than TIMEOUT_CYCLES, then send a full 0x2B -> numbers=16'h8000, no frame_err. Assert rst mid-frame -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/ps2_key_decoder_if.sv
// rtl/ps2_key_decoder_if.sv - PS/2 line inputs and decoded key level outputs of ps2_key_decoder.
interface ps2_key_decoder_if;
  logic        ps2ck;
  logic        ps2dt;
  logic [15:0] numbers;
  logic        keyBackspace;
  logic        delete;
  logic        scan_valid;
  logic [7:0]  scan_code;
  logic        frame_err;

  modport master (
    output ps2ck, ps2dt,
    input  numbers, keyBackspace, delete, scan_valid, scan_code, frame_err
  );

  modport slave (
    input  ps2ck, ps2dt,
    output numbers, keyBackspace, delete, scan_valid, scan_code, frame_err
  );
endinterface

// File: rtl/ps2_key_decoder.sv
// rtl/ps2_key_decoder.sv - PS/2 frame receiver and make/break decoder for hex entry keys.
// Optional odd-parity checking is enabled by defining PS2_PARITY_CHECK_EN.
module ps2_key_decoder #(
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic            clk,
  input  logic            rst,
  ps2_key_decoder_if.slave bus
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {S_IDLE, S_RECV, S_CHECK} state_t;

  logic [SYNC_STAGES-1:0] ck_sync_q;
  logic [SYNC_STAGES-1:0] dt_sync_q;
  logic                   ck_prev_q;
  state_t                 state_q;
  logic [3:0]             bit_cnt_q;
  logic [9:0]             shift_q;
  logic [TW-1:0]          to_cnt_q;
  logic                   ext_q, ext_d;
  logic                   brk_q, brk_d;
  logic [17:0]            keys_q, keys_d;
  logic                   scan_valid_q;
  logic [7:0]             scan_code_q;
  logic                   frame_err_q;

  logic                   ck_s, dt_s, fall, timeout, frame_ok;
  logic [17:0]            key_map;

  assign ck_s    = ck_sync_q[SYNC_STAGES-1];
  assign dt_s    = dt_sync_q[SYNC_STAGES-1];
  assign fall    = ck_prev_q & ~ck_s;
  assign timeout = (to_cnt_q == TW'(TIMEOUT_CYCLES));

  // After ten LSB-first shifts: [7:0] data, [8] parity, [9] stop.
`ifdef PS2_PARITY_CHECK_EN
  assign frame_ok = shift_q[9] & (^shift_q[8:0]);
`else
  logic unused_parity;
  assign unused_parity = shift_q[8];
  assign frame_ok      = shift_q[9];
`endif

  // Key vector layout: [15:0] hex digits, [16] Backspace, [17] Delete.
  function automatic logic [17:0] map_key(input logic [7:0] code, input logic ext);
    logic [17:0] k;
    k = '0;
    if (ext) begin
      if (code == 8'h71) k[17] = 1'b1;
    end else begin
      case (code)
        8'h45: k[0]  = 1'b1;
        8'h16: k[1]  = 1'b1;
        8'h1E: k[2]  = 1'b1;
        8'h26: k[3]  = 1'b1;
        8'h25: k[4]  = 1'b1;
        8'h2E: k[5]  = 1'b1;
        8'h36: k[6]  = 1'b1;
        8'h3D: k[7]  = 1'b1;
        8'h3E: k[8]  = 1'b1;
        8'h46: k[9]  = 1'b1;
        8'h1C: k[10] = 1'b1;
        8'h32: k[11] = 1'b1;
        8'h21: k[12] = 1'b1;
        8'h23: k[13] = 1'b1;
        8'h24: k[14] = 1'b1;
        8'h2B: k[15] = 1'b1;
        8'h66: k[16] = 1'b1;
        default: k = '0;
      endcase
    end
    return k;
  endfunction

  always_comb begin
    key_map = map_key(shift_q[7:0], ext_q);
    ext_d   = ext_q;
    brk_d   = brk_q;
    keys_d  = keys_q;
    if (shift_q[7:0] == 8'hE0) begin
      ext_d = 1'b1;
    end else if (shift_q[7:0] == 8'hF0) begin
      brk_d = 1'b1;
    end else begin
      ext_d = 1'b0;
      brk_d = 1'b0;
      // Make replaces the held key; break only releases the key actually held.
      if (key_map != '0) begin
        if (!brk_q)                keys_d = key_map;
        else if (key_map == keys_q) keys_d = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ck_sync_q <= '1;
      dt_sync_q <= '1;
    end else begin
      ck_sync_q <= {ck_sync_q[SYNC_STAGES-2:0], bus.ps2ck};
      dt_sync_q <= {dt_sync_q[SYNC_STAGES-2:0], bus.ps2dt};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ck_prev_q    <= 1'b1;
      state_q      <= S_IDLE;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      to_cnt_q     <= '0;
      ext_q        <= 1'b0;
      brk_q        <= 1'b0;
      keys_q       <= '0;
      scan_valid_q <= 1'b0;
      scan_code_q  <= '0;
      frame_err_q  <= 1'b0;
    end else begin
      ck_prev_q    <= ck_s;
      scan_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;

      if (fall)          to_cnt_q <= '0;
      else if (!timeout) to_cnt_q <= to_cnt_q + 1'b1;

      case (state_q)
        S_IDLE: begin
          bit_cnt_q <= '0;
          if (fall && !dt_s) state_q <= S_RECV;
        end
        S_RECV: begin
          if (fall) begin
            shift_q   <= {dt_s, shift_q[9:1]};
            bit_cnt_q <= bit_cnt_q + 1'b1;
            if (bit_cnt_q == 4'd9) state_q <= S_CHECK;
          end else if (timeout) begin
            state_q   <= S_IDLE;
            bit_cnt_q <= '0;
          end
        end
        S_CHECK: begin
          state_q   <= S_IDLE;
          bit_cnt_q <= '0;
          if (frame_ok) begin
            scan_valid_q <= 1'b1;
            scan_code_q  <= shift_q[7:0];
            ext_q        <= ext_d;
            brk_q        <= brk_d;
            keys_q       <= keys_d;
          end else begin
            frame_err_q  <= 1'b1;
          end
        end
        default: begin
          state_q   <= S_IDLE;
          bit_cnt_q <= '0;
        end
      endcase
    end
  end

  assign bus.numbers      = keys_q[15:0];
  assign bus.keyBackspace = keys_q[16];
  assign bus.delete       = keys_q[17];
  assign bus.scan_valid   = scan_valid_q;
  assign bus.scan_code    = scan_code_q;
  assign bus.frame_err    = frame_err_q;

endmodule
